// File: rtl/id_stage_pipe_pkg.sv
// id_pkg: opcode, ALU-control, branch-op and ALUop encodings shared by the ID stage.
package id_pkg;
    localparam int XLEN_D     = 32;
    localparam int NUM_REGS_D = 32;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [1:0] BR_EQ = 2'b00;
    localparam logic [1:0] BR_NE = 2'b01;
    localparam logic [1:0] BR_LT = 2'b10;
    localparam logic [1:0] BR_GE = 2'b11;
    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_FN  = 2'b10;
    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       mem_read;
        logic       branch;
        logic       mem_to_reg;
        logic       sltc;
        logic       illegal;
        logic [2:0] alu_control;
        logic [1:0] branch_op;
    } ctrl_t;
endpackage

// File: rtl/id_stage_pipe_regfile.sv
// regfile_bypass: register file with sync active-low reset, hardwired x0 and write-through reads.
module regfile_bypass
    import id_pkg::*;
#(
    parameter int XLEN     = XLEN_D,
    parameter int NUM_REGS = NUM_REGS_D,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr1,
    input  logic [AW-1:0]   i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2
);
    logic [XLEN-1:0] r_mem [NUM_REGS];
    logic            w_wr;

    assign w_wr = i_we && i_waddr != '0;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int k = 0; k < NUM_REGS; k++) r_mem[k] <= '0;
        end else if (w_wr) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = i_raddr1 == '0 ? '0 : (w_wr && i_waddr == i_raddr1) ? i_wdata : r_mem[i_raddr1];
    assign o_rdata2 = i_raddr2 == '0 ? '0 : (w_wr && i_waddr == i_raddr2) ? i_wdata : r_mem[i_raddr2];
endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RISC-V decode stage with handshaked ID/EX register, load-use stall and flush.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter  int XLEN     = XLEN_D,
    parameter  int NUM_REGS = NUM_REGS_D,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    input  logic [31:0]     i_instruccion,
    output logic            o_ready,
    input  logic            i_ready,
    input  logic            i_flush,
    input  logic            i_RegWrite,
    input  logic [AW-1:0]   i_WriteReg,
    input  logic [XLEN-1:0] i_WriteData,
    output logic            o_valid,
    output logic [XLEN-1:0] o_register1,
    output logic [XLEN-1:0] o_register2,
    output logic [XLEN-1:0] o_constante,
    output logic [AW-1:0]   o_rs1,
    output logic [AW-1:0]   o_rs2,
    output logic [AW-1:0]   o_WriteReg,
    output logic            o_RegWrite,
    output logic            o_ALUSrc,
    output logic            o_MemWrite,
    output logic            o_MemRead,
    output logic            o_Branch,
    output logic            o_MemToReg,
    output logic            o_SLTc,
    output logic            o_illegal,
    output logic [2:0]      o_ALUControl,
    output logic [1:0]      o_BranchOp
);
    logic [6:0]      w_op;
    logic [2:0]      w_f3;
    logic [AW-1:0]   w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0] w_rdata1, w_rdata2, w_imm;
    logic [1:0]      w_aluop, w_bop;
    logic [2:0]      w_fn;
    ctrl_t           w_ctrl;
    logic            w_uses_rs2, w_hazard, w_advance, w_take;
    logic            r_valid;
    ctrl_t           r_ctrl;
    logic [XLEN-1:0] r_reg1, r_reg2, r_imm;
    logic [AW-1:0]   r_rs1, r_rs2, r_rd;

    assign w_op  = i_instruccion[6:0];
    assign w_f3  = i_instruccion[14:12];
    assign w_rs1 = AW'(i_instruccion[19:15]);
    assign w_rs2 = AW'(i_instruccion[24:20]);
    assign w_rd  = AW'(i_instruccion[11:7]);

    regfile_bypass #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .AW(AW)) u_rf (
        .i_clk(i_clk), .i_reset(i_reset), .i_we(i_RegWrite), .i_waddr(i_WriteReg),
        .i_wdata(i_WriteData), .i_raddr1(w_rs1), .i_raddr2(w_rs2),
        .o_rdata1(w_rdata1), .o_rdata2(w_rdata2)
    );

    assign w_fn = w_f3 == 3'b000 ? ((w_op == OP_R && i_instruccion[30]) ? ALU_SUB : ALU_ADD) :
                  w_f3 == 3'b100 ? ALU_XOR :
                  w_f3 == 3'b110 ? ALU_OR  :
                  w_f3 == 3'b111 ? ALU_AND :
                  w_f3[2:1] == 2'b01 ? ALU_SLT : ALU_ADD;
    assign w_bop = w_f3 == 3'b001 ? BR_NE : w_f3 == 3'b100 ? BR_LT : w_f3 == 3'b101 ? BR_GE : BR_EQ;

    always_comb begin
        w_ctrl  = '0;
        w_aluop = ALUOP_MEM;
        w_imm   = '0;
        case (w_op)
            OP_R: begin
                w_ctrl.reg_write = 1'b1;
                w_aluop          = ALUOP_FN;
            end
            OP_I: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_aluop          = ALUOP_FN;
                w_imm            = {{(XLEN-12){i_instruccion[31]}}, i_instruccion[31:20]};
            end
            OP_LD: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_imm             = {{(XLEN-12){i_instruccion[31]}}, i_instruccion[31:20]};
            end
            OP_ST: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.mem_write = 1'b1;
                w_imm            = {{(XLEN-12){i_instruccion[31]}}, i_instruccion[31:25], i_instruccion[11:7]};
            end
            OP_BR: begin
                w_ctrl.branch = 1'b1;
                w_aluop       = ALUOP_BR;
                w_imm         = {{(XLEN-13){i_instruccion[31]}}, i_instruccion[31], i_instruccion[7],
                                 i_instruccion[30:25], i_instruccion[11:8], 1'b0};
            end
            default: w_ctrl.illegal = 1'b1;
        endcase
        w_ctrl.sltc        = w_aluop == ALUOP_FN && w_f3 == 3'b011;
        w_ctrl.alu_control = w_ctrl.illegal ? 3'b000 : w_aluop == ALUOP_MEM ? ALU_ADD :
                             w_aluop == ALUOP_BR ? ALU_SUB : w_fn;
        w_ctrl.branch_op   = w_ctrl.branch ? w_bop : BR_EQ;
    end

    // A load in ID/EX whose destination feeds this instruction must wait one cycle.
    assign w_uses_rs2 = w_op == OP_R || w_op == OP_ST || w_op == OP_BR;
    assign w_hazard   = r_valid && r_ctrl.mem_read && r_rd != '0 &&
                        (r_rd == w_rs1 || (w_uses_rs2 && r_rd == w_rs2));
    assign w_advance  = i_ready || !r_valid;
    assign o_ready    = w_advance && !w_hazard;
    assign w_take     = i_valid && o_ready;

    always_ff @(posedge i_clk) begin
        if (!i_reset || i_flush || (w_advance && !w_take)) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_reg1  <= '0;
            r_reg2  <= '0;
            r_imm   <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
        end else if (w_take) begin
            r_valid <= 1'b1;
            r_ctrl  <= w_ctrl;
            r_reg1  <= w_rdata1;
            r_reg2  <= w_rdata2;
            r_imm   <= w_imm;
            r_rs1   <= w_rs1;
            r_rs2   <= w_rs2;
            r_rd    <= w_rd;
        end
    end

    assign o_valid      = r_valid;
    assign o_register1  = r_reg1;
    assign o_register2  = r_reg2;
    assign o_constante  = r_imm;
    assign o_rs1        = r_rs1;
    assign o_rs2        = r_rs2;
    assign o_WriteReg   = r_rd;
    assign o_RegWrite   = r_ctrl.reg_write;
    assign o_ALUSrc     = r_ctrl.alu_src;
    assign o_MemWrite   = r_ctrl.mem_write;
    assign o_MemRead    = r_ctrl.mem_read;
    assign o_Branch     = r_ctrl.branch;
    assign o_MemToReg   = r_ctrl.mem_to_reg;
    assign o_SLTc       = r_ctrl.sltc;
    assign o_illegal    = r_ctrl.illegal;
    assign o_ALUControl = r_ctrl.alu_control;
    assign o_BranchOp   = r_ctrl.branch_op;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: random and directed stimulus against a mnemonic-level model of the ID stage.
module tb_id_stage_pipe;
    logic        clk = 1'b0;
    logic        rst_n, valid, flush, ex_ready, reg_write;
    logic [31:0] instr, write_data;
    logic [4:0]  write_reg;
    logic        o_ready, o_valid, o_RegWrite, o_ALUSrc, o_MemWrite, o_MemRead, o_Branch;
    logic        o_MemToReg, o_SLTc, o_illegal;
    logic [31:0] o_register1, o_register2, o_constante;
    logic [4:0]  o_rs1, o_rs2, o_WriteReg;
    logic [2:0]  o_ALUControl;
    logic [1:0]  o_BranchOp;
    int          checks = 0;
    int          errors = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] r1, r2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, as, mw, mr, br, m2r, sltc, ill;
        logic [2:0]  aluc;
        logic [1:0]  bop;
    } exp_t;

    exp_t        m;
    logic [31:0] m_regs [32];

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .i_clk(clk), .i_reset(rst_n), .i_valid(valid), .i_instruccion(instr), .o_ready(o_ready),
        .i_ready(ex_ready), .i_flush(flush), .i_RegWrite(reg_write), .i_WriteReg(write_reg),
        .i_WriteData(write_data), .o_valid(o_valid), .o_register1(o_register1),
        .o_register2(o_register2), .o_constante(o_constante), .o_rs1(o_rs1), .o_rs2(o_rs2),
        .o_WriteReg(o_WriteReg), .o_RegWrite(o_RegWrite), .o_ALUSrc(o_ALUSrc),
        .o_MemWrite(o_MemWrite), .o_MemRead(o_MemRead), .o_Branch(o_Branch),
        .o_MemToReg(o_MemToReg), .o_SLTc(o_SLTc), .o_illegal(o_illegal),
        .o_ALUControl(o_ALUControl), .o_BranchOp(o_BranchOp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] read_reg(input logic [4:0] a);
        if (a == 0) return 0;
        if (reg_write && write_reg == a) return write_data;
        return m_regs[a];
    endfunction

    function automatic logic [2:0] alu_fn(input logic [2:0] f3, input logic sub);
        case (f3)
            3'd0:       return sub ? 3'b110 : 3'b010;
            3'd4:       return 3'b011;
            3'd6:       return 3'b001;
            3'd7:       return 3'b000;
            3'd2, 3'd3: return 3'b111;
            default:    return 3'b010;
        endcase
    endfunction

    function automatic exp_t decode(input logic [31:0] w);
        exp_t e = '0;
        logic [2:0] f3 = w[14:12];
        e.valid = 1;
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.rd  = w[11:7];
        e.r1  = read_reg(e.rs1);
        e.r2  = read_reg(e.rs2);
        case (w[6:0])
            7'b0110011: begin e.rw = 1; e.aluc = alu_fn(f3, w[30]); e.sltc = f3 == 3; end
            7'b0010011: begin
                e.rw = 1; e.as = 1; e.aluc = alu_fn(f3, 0); e.sltc = f3 == 3;
                e.imm = 32'($signed(w[31:20]));
            end
            7'b0000011: begin
                e.rw = 1; e.as = 1; e.mr = 1; e.m2r = 1; e.aluc = 3'b010;
                e.imm = 32'($signed(w[31:20]));
            end
            7'b0100011: begin
                e.as = 1; e.mw = 1; e.aluc = 3'b010;
                e.imm = 32'($signed({w[31:25], w[11:7]}));
            end
            7'b1100011: begin
                e.br = 1; e.aluc = 3'b110;
                e.bop = f3 == 1 ? 2'b01 : f3 == 4 ? 2'b10 : f3 == 5 ? 2'b11 : 2'b00;
                e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            end
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    function automatic logic uses_rs2(input logic [31:0] w);
        return w[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    task automatic compare_outputs();
        check("valid", o_valid, m.valid);
        check("reg1", o_register1, m.r1);
        check("reg2", o_register2, m.r2);
        check("imm", o_constante, m.imm);
        check("rs1", o_rs1, m.rs1);
        check("rs2", o_rs2, m.rs2);
        check("rd", o_WriteReg, m.rd);
        check("ctrl", {o_RegWrite, o_ALUSrc, o_MemWrite, o_MemRead, o_Branch, o_MemToReg, o_SLTc, o_illegal},
              {m.rw, m.as, m.mw, m.mr, m.br, m.m2r, m.sltc, m.ill});
        check("aluctl", o_ALUControl, m.aluc);
        check("brop", o_BranchOp, m.bop);
    endtask

    task automatic cycle(input logic r, input logic v, input logic fl, input logic rdy, input logic rw,
                         input logic [4:0] wr, input logic [31:0] wd, input logic [31:0] ins);
        logic stall, adv;
        rst_n = r; valid = v; flush = fl; ex_ready = rdy;
        reg_write = rw; write_reg = wr; write_data = wd; instr = ins;
        #1;
        stall = m.valid && m.mr && m.rd != 0 &&
                (m.rd == ins[19:15] || (uses_rs2(ins) && m.rd == ins[24:20]));
        adv = rdy || !m.valid;
        check("ready", o_ready, adv && !stall);
        if (!r) begin
            m = '0;
            for (int k = 0; k < 32; k++) m_regs[k] = 0;
        end else begin
            if (fl) m = '0;
            else if (adv) m = (v && !stall) ? decode(ins) : '0;
            if (rw && wr != 0) m_regs[wr] = wd;
        end
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    function automatic logic [31:0] add_i(input logic [4:0] rd, rs1, rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] lw_i(input logic [4:0] rd, rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] sw_i(input logic [4:0] rs2, rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] beq_i(input logic [4:0] rs1, rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [4:0]  a = 5'($urandom_range(0, 7));
        logic [4:0]  b = 5'($urandom_range(0, 7));
        logic [4:0]  d = 5'($urandom_range(0, 7));
        logic [2:0]  f = 3'($urandom);
        logic [11:0] im = 12'($urandom);
        logic        s = 1'($urandom);
        case ($urandom_range(0, 5))
            0:       return {1'b0, s, 5'b0, b, a, f, d, 7'b0110011};
            1:       return {im, a, f, d, 7'b0010011};
            2:       return lw_i(d, a, im);
            3:       return sw_i(b, a, im);
            4:       return {im[11:5], b, a, f, im[4:0], 7'b1100011};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        m = '0;
        for (int k = 0; k < 32; k++) m_regs[k] = 32'hx;
        cycle(0, 0, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0, 0);
        cycle(1, 1, 0, 1, 1, 5, 32'h1234, add_i(6, 5, 5));
        check("bypass_r1", o_register1, 32'h1234);
        check("bypass_r2", o_register2, 32'h1234);
        check("add_aluctl", o_ALUControl, 3'b010);
        cycle(1, 1, 0, 1, 1, 2, 32'h55, lw_i(7, 1, 0));
        cycle(1, 1, 0, 1, 0, 0, 0, add_i(8, 7, 2));
        check("lu_bubble", o_valid, 1'b0);
        cycle(1, 1, 0, 1, 0, 0, 0, add_i(8, 7, 2));
        check("lu_add", o_WriteReg, 5'd8);
        cycle(1, 1, 0, 1, 0, 0, 0, lw_i(7, 1, 12'h010));
        cycle(1, 1, 0, 1, 0, 0, 0, add_i(9, 1, 0));
        cycle(1, 1, 0, 1, 0, 0, 0, lw_i(0, 1, 12'h004));
        cycle(1, 1, 0, 1, 0, 0, 0, add_i(10, 0, 0));
        check("x0_nostall", o_valid, 1'b1);
        cycle(1, 1, 0, 1, 1, 3, 32'hBEEF, sw_i(3, 2, 12'hFFC));
        for (int k = 0; k < 3; k++) begin
            cycle(1, 1, 0, 0, 0, 0, 0, add_i(11, 1, 1));
            check("hold_imm", o_constante, 32'hFFFFFFFC);
            check("hold_ready", o_ready, 1'b0);
        end
        cycle(1, 1, 1, 1, 0, 0, 0, beq_i(1, 2, 13'h1FF8));
        check("flush_valid", o_valid, 1'b0);
        cycle(1, 0, 0, 1, 0, 0, 0, beq_i(1, 2, 13'h1FF8));
        cycle(1, 1, 0, 1, 0, 0, 0, beq_i(1, 2, 13'h1FF8));
        check("beq_imm", o_constante, 32'hFFFFFFF8);
        cycle(1, 1, 0, 1, 1, 0, 32'hDEAD, 32'h0000007F);
        check("illegal", o_illegal, 1'b1);
        cycle(1, 1, 0, 1, 0, 0, 0, add_i(9, 0, 0));
        check("x0_zero", o_register1, 32'h0);
        cycle(1, 1, 0, 1, 0, 0, 0, lw_i(7, 1, 0));
        cycle(0, 1, 0, 1, 0, 0, 0, add_i(8, 7, 2));
        check("rst_valid", o_valid, 1'b0);
        cycle(1, 1, 0, 1, 0, 0, 0, add_i(12, 5, 3));
        check("rst_regs", o_register1 | o_register2, 32'h0);
        for (int n = 0; n < 2000; n++)
            cycle($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 2) != 0, 1'($urandom), 5'($urandom_range(0, 7)), $urandom, rand_ins());
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
